// File: rtl/cpu_pkg.sv
// Shared CPU-wide defaults and register-index types used by the register file,
// the writeback stage and the operand fetch stage.
package cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGISTERS = 32;
  localparam int DEFAULT_CTRL_WIDTH    = 16;
  localparam int DEFAULT_IDX_W         = $clog2(DEFAULT_NUM_REGISTERS);

  typedef logic [DEFAULT_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register "long-latency write outstanding" bits with one set port, one clear
// port and three combinational pending lookups.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
  localparam int IDX_W         = $clog2(NUM_REGISTERS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] look_a,
  input  logic [IDX_W-1:0] look_b,
  input  logic [IDX_W-1:0] look_c,
  output logic             pend_a,
  output logic             pend_b,
  output logic             pend_c
);

  logic [NUM_REGISTERS-1:0] sb_reg;
  logic [NUM_REGISTERS-1:0] sb_next;

  // Set is evaluated after clear so a same-edge set/clear leaves the bit set.
  generate
    for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign sb_next[gi] = 1'b0;
      end else begin : g_live
        assign sb_next[gi] = (set_en && set_idx == IDX_W'(gi)) ||
                             (sb_reg[gi] && !(clr_en && clr_idx == IDX_W'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) sb_reg <= '0;
    else      sb_reg <= sb_next;
  end

  // A writeback retiring this cycle already satisfies the dependency.
  assign pend_a = sb_reg[look_a] && (look_a != '0) && !(clr_en && clr_idx == look_a);
  assign pend_b = sb_reg[look_b] && (look_b != '0) && !(clr_en && clr_idx == look_b);
  assign pend_c = sb_reg[look_c] && (look_c != '0) && !(clr_en && clr_idx == look_c);

endmodule

// File: rtl/operand_fetch.sv
// Decode->execute stage: register-file reads with same-cycle writeback bypass,
// long-latency hazard stall via scoreboard, and a valid/ready output register.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
  parameter  int CTRL_WIDTH    = DEFAULT_CTRL_WIDTH,
  localparam int IDX_W         = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_rs1,
  input  logic [IDX_W-1:0]      in_rs2,
  input  logic [IDX_W-1:0]      in_rd,
  input  logic                  in_long,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic [IDX_W-1:0]      rf_read_register_1,
  output logic [IDX_W-1:0]      rf_read_register_2,
  input  logic [DATA_WIDTH-1:0] rf_result_1,
  input  logic [DATA_WIDTH-1:0] rf_result_2,
  input  logic [IDX_W-1:0]      wb_register,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_long_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_operand_1,
  output logic [DATA_WIDTH-1:0] out_operand_2,
  output logic [IDX_W-1:0]      out_rd,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_long
);

  logic                  pend_rs1, pend_rs2, pend_rd;
  logic                  hazard, accept, sb_set, sb_clear;
  logic [DATA_WIDTH-1:0] operand_1_next, operand_2_next;

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_operand_1_reg, out_operand_2_reg;
  logic [IDX_W-1:0]      out_rd_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;
  logic                  out_long_reg;

  assign rf_read_register_1 = in_rs1;
  assign rf_read_register_2 = in_rs2;

  assign sb_clear = wb_long_done && (wb_register != '0);
  assign sb_set   = accept && in_long && (in_rd != '0);

  reg_scoreboard #(.NUM_REGISTERS(NUM_REGISTERS)) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (sb_set),
    .set_idx(in_rd),
    .clr_en (sb_clear),
    .clr_idx(wb_register),
    .look_a (in_rs1),
    .look_b (in_rs2),
    .look_c (in_rd),
    .pend_a (pend_rs1),
    .pend_b (pend_rs2),
    .pend_c (pend_rd)
  );

  // WAW on rd stalls too, so a younger long op never races an older one's retire.
  assign hazard   = in_valid && (pend_rs1 || pend_rs2 || pend_rd);
  assign in_ready = rst && !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // The register file only shows the write on the next cycle, so bypass it here.
  assign operand_1_next = (in_rs1 == '0) ? '0 :
                          (wb_register == in_rs1) ? wb_data : rf_result_1;
  assign operand_2_next = (in_rs2 == '0) ? '0 :
                          (wb_register == in_rs2) ? wb_data : rf_result_2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_reg     <= 1'b0;
      out_operand_1_reg <= '0;
      out_operand_2_reg <= '0;
      out_rd_reg        <= '0;
      out_ctrl_reg      <= '0;
      out_long_reg      <= 1'b0;
    end else if (accept) begin
      out_valid_reg     <= 1'b1;
      out_operand_1_reg <= operand_1_next;
      out_operand_2_reg <= operand_2_next;
      out_rd_reg        <= in_rd;
      out_ctrl_reg      <= in_ctrl;
      out_long_reg      <= in_long;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_operand_1 = out_operand_1_reg;
  assign out_operand_2 = out_operand_2_reg;
  assign out_rd        = out_rd_reg;
  assign out_ctrl      = out_ctrl_reg;
  assign out_long      = out_long_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scenarios plus randomized traffic for operand_fetch, checked every
// cycle against a register-level reference model held in the bench.
module tb_operand_fetch;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_long, wb_long_done;
  logic          out_valid, out_ready, out_long;
  logic [IW-1:0] in_rs1, in_rs2, in_rd, wb_register, out_rd;
  logic [IW-1:0] rf_read_register_1, rf_read_register_2;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] rf_result_1, rf_result_2, wb_data, out_operand_1, out_operand_2;

  logic [DW-1:0] rf_mem [NR];

  // Reference model state
  bit            m_valid;
  logic [DW-1:0] m_op1, m_op2;
  logic [IW-1:0] m_rd;
  logic [CW-1:0] m_ctrl;
  bit            m_long;
  bit            m_sb [NR];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_result_1 = rf_mem[rf_read_register_1];
  assign rf_result_2 = rf_mem[rf_read_register_2];

  operand_fetch #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_long(in_long), .in_ctrl(in_ctrl),
    .rf_read_register_1(rf_read_register_1), .rf_read_register_2(rf_read_register_2),
    .rf_result_1(rf_result_1), .rf_result_2(rf_result_2),
    .wb_register(wb_register), .wb_data(wb_data), .wb_long_done(wb_long_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_long(out_long)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_pend(input int r);
    return m_sb[r] && (r != 0) && !(wb_long_done && int'(wb_register) == r);
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = in_valid && (m_pend(int'(in_rs1)) || m_pend(int'(in_rs2)) || m_pend(int'(in_rd)));
    return rst && !flush && !hz && (!m_valid || out_ready);
  endfunction

  function automatic logic [DW-1:0] m_operand(input int s);
    if (s == 0) return '0;
    if (wb_register != REG_ZERO && int'(wb_register) == s) return wb_data;
    return rf_mem[s];
  endfunction

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_long = 1'b0; in_ctrl = '0; wb_register = '0; wb_data = '0;
    wb_long_done = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_op(input int rs1, input int rs2, input int rd, input bit lng, input int ctrl);
    in_valid = 1'b1;
    in_rs1 = IW'(rs1); in_rs2 = IW'(rs2); in_rd = IW'(rd);
    in_long = lng; in_ctrl = CW'(ctrl);
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    bit acc, pre_rst, pre_flush, pre_oready, pre_long, pre_done;
    logic [DW-1:0] n_op1, n_op2, pre_wdata;
    logic [IW-1:0] pre_rd, pre_wreg;
    logic [CW-1:0] pre_ctrl;
    #2;
    acc = in_valid && m_ready();
    check("in_ready",  64'(in_ready), 64'(m_ready()));
    check("rf_addr1",  64'(rf_read_register_1), 64'(in_rs1));
    check("rf_addr2",  64'(rf_read_register_2), 64'(in_rs2));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_op1",   64'(out_operand_1), 64'(m_op1));
    check("out_op2",   64'(out_operand_2), 64'(m_op2));
    check("out_rd",    64'(out_rd), 64'(m_rd));
    check("out_ctrl",  64'(out_ctrl), 64'(m_ctrl));
    check("out_long",  64'(out_long), 64'(m_long));
    n_op1 = m_operand(int'(in_rs1));
    n_op2 = m_operand(int'(in_rs2));
    pre_rst = rst; pre_flush = flush; pre_oready = out_ready; pre_long = in_long;
    pre_done = wb_long_done; pre_rd = in_rd; pre_ctrl = in_ctrl;
    pre_wreg = wb_register; pre_wdata = wb_data;
    @(posedge clk);
    #1;
    if (!pre_rst) begin
      m_valid = 0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_ctrl = '0; m_long = 0;
      foreach (m_sb[i]) m_sb[i] = 0;
    end else begin
      if (acc) begin
        m_valid = 1; m_op1 = n_op1; m_op2 = n_op2; m_rd = pre_rd; m_ctrl = pre_ctrl; m_long = pre_long;
        $display("accept rd=%0d long=%0d ctrl=0x%04h op1=0x%08h op2=0x%08h", pre_rd, pre_long, pre_ctrl, n_op1, n_op2);
      end else if (pre_flush || pre_oready) begin
        m_valid = 0;
      end
      if (pre_done && pre_wreg != REG_ZERO) m_sb[pre_wreg] = 0;
      if (acc && pre_long && pre_rd != REG_ZERO) m_sb[pre_rd] = 1;
    end
    if (pre_wreg != REG_ZERO) rf_mem[pre_wreg] = pre_wdata;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    foreach (rf_mem[i]) rf_mem[i] = (i == 0) ? '0 : DW'($urandom);
    m_valid = 0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_ctrl = '0; m_long = 0;
    foreach (m_sb[i]) m_sb[i] = 0;
    @(negedge clk);

    // Reset held with a valid op presented
    set_op(1, 2, 3, 1'b0, 16'h0101);
    for (int i = 0; i < 3; i++) begin
      #1 check("rst_in_ready", 64'(in_ready), 64'(0));
      step();
    end
    rst = 1'b1;
    idle();
    #1 check("post_rst_ready", 64'(in_ready), 64'(1));
    step();

    // Writeback bypass into operand 1, x0 reads as zero
    rf_mem[5] = 32'h11;
    set_op(5, 0, 3, 1'b0, 16'h1234);
    wb_register = 5'd5; wb_data = 32'hAB;
    step();
    idle();
    check("bypass_op1", 64'(out_operand_1), 64'(32'hAB));
    check("bypass_op2", 64'(out_operand_2), 64'(0));
    step();

    // RAW stall behind a long load to x7
    set_op(0, 0, 7, 1'b1, 16'h0007);
    step();
    set_op(0, 7, 1, 1'b0, 16'h0070);
    for (int i = 0; i < 4; i++) begin
      #1 check("raw_stall", 64'(in_ready), 64'(0));
      step();
    end
    wb_register = 5'd7; wb_data = 32'h55; wb_long_done = 1'b1;
    #1 check("raw_release", 64'(in_ready), 64'(1));
    step();
    idle();
    set_op(7, 0, 2, 1'b0, 16'h0700);
    #1 check("raw_op2", 64'(out_operand_2), 64'(32'h55));
    check("raw_cleared", 64'(in_ready), 64'(1));
    step();

    // Backpressure: output held, then back-to-back flow
    set_op(3, 4, 5, 1'b0, 16'hBEEF);
    step();
    out_ready = 1'b0;
    set_op(6, 8, 10, 1'b0, 16'hCAFE);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_ready", 64'(in_ready), 64'(0));
      check("bp_ctrl_held", 64'(out_ctrl), 64'(16'hBEEF));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(i + 1, i + 2, i + 11, 1'b0, 16'hA000 + i);
      #1 check("b2b_ready", 64'(in_ready), 64'(1));
      step();
    end
    idle();

    // Same-edge set/clear on x9: the new long op's set wins
    set_op(0, 0, 9, 1'b1, 16'h0009);
    step();
    set_op(0, 0, 9, 1'b1, 16'h0090);
    wb_register = 5'd9; wb_data = 32'h99; wb_long_done = 1'b1;
    #1 check("collide_accept", 64'(in_ready), 64'(1));
    step();
    idle();
    set_op(9, 0, 0, 1'b0, 16'h0900);
    #1 check("collide_still_set", 64'(in_ready), 64'(0));
    step();
    idle();
    wb_register = 5'd9; wb_data = 32'h9A; wb_long_done = 1'b1;
    step();
    idle();

    // Flush drops the output op but keeps the scoreboard
    set_op(0, 0, 7, 1'b1, 16'h0077);
    step();
    set_op(0, 0, 4, 1'b0, 16'h0044);
    flush = 1'b1; out_ready = 1'b0;
    #1 check("flush_no_accept", 64'(in_ready), 64'(0));
    step();
    idle();
    set_op(7, 0, 0, 1'b0, 16'h0700);
    #1 check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_x7_pending", 64'(in_ready), 64'(0));
    step();
    idle();
    wb_register = 5'd7; wb_data = 32'h77; wb_long_done = 1'b1;
    step();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      flush        = ($urandom_range(0, 99) < 5);
      in_valid     = ($urandom_range(0, 99) < 75);
      in_rs1       = IW'($urandom_range(0, 7));
      in_rs2       = IW'($urandom_range(0, 7));
      in_rd        = IW'($urandom_range(0, 7));
      in_long      = ($urandom_range(0, 99) < 25);
      in_ctrl      = CW'($urandom);
      out_ready    = ($urandom_range(0, 99) < 70);
      wb_register  = ($urandom_range(0, 1) != 0) ? IW'($urandom_range(0, 7)) : '0;
      wb_data      = DW'($urandom);
      wb_long_done = ($urandom_range(0, 99) < 40);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
